// File: rtl/channel_timing_sink.sv
// Purpose : clockless timing model of a four-phase channel receiver with an acknowledge-low handshake.
// Latency : the enable falls fb_valid after capture and rises fb_neutral after neutral data, no earlier than cycle_time after the last capture.
// Backpr. : the producer is throttled by the enable, by optional injected stalls and, once max_tokens is reached, permanently.
//
// Ports:
//   _RESET    in   async active-low reset; every pending wait is abandoned
//   L_data    in   signed channel data; negative = neutral, >= 0 = valid token
//   L_enable  out  receiver enable towards the producer
//   tok_data  out  last captured token (-1 after reset)
//   tok_count out  tokens consumed since reset, wraps modulo 2^32
//   proto_err out  sticky protocol-violation flag
//   done      out  token limit reached (only when max_tokens > 0)

`ifndef PRS2VERILOG_TAU
`define PRS2VERILOG_TAU 1.0
`endif

module channel_timing_sink #(
   parameter int  bit_width    = 1,
   parameter real cycle_time   = 18.0,
   parameter real fb_valid     = 6.75,
   parameter real fb_neutral   = 7.25,
   parameter int  stall_period = 0,
   parameter real stall_len    = 0.0,
   parameter int  max_tokens   = 0
) (
   input  logic                        _RESET,
   input  logic signed [bit_width:0]   L_data,
   output logic                        L_enable,
   output logic signed [bit_width:0]   tok_data,
   output logic [31:0]                 tok_count,
   output logic                        proto_err,
   output logic                        done
);
   timeunit 1ns;
   timeprecision 1fs;

   localparam real TAU  = `PRS2VERILOG_TAU;
   // Long delays are slept in short slices so that a reset pulse is noticed
   // quickly; the final slice is trimmed so the total delay stays exact.
   localparam real POLL = 0.125 * TAU;
   localparam real EPS  = 1.0e-7;

   // Negative delays collapse to zero.
   localparam real CT_D      = (cycle_time > 0.0) ? cycle_time * TAU : 0.0;
   localparam real FBV_D     = (fb_valid   > 0.0) ? fb_valid   * TAU : 0.0;
   localparam real FBN_D     = (fb_neutral > 0.0) ? fb_neutral * TAU : 0.0;
   localparam real STALL_D   = (stall_len  > 0.0) ? stall_len  * TAU : 0.0;
   localparam bit  HAS_NEG   = (cycle_time < 0.0) || (fb_valid < 0.0) ||
                               (fb_neutral < 0.0) || (stall_len < 0.0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENABLE,
      ST_HOLD,
      ST_RELEASE,
      ST_RECOVER
   } state_t;

   state_t                    state_q;
   logic                      en_q;
   logic                      done_q;
   logic                      main_err_q;
   logic                      mon_err_q;
   logic signed [bit_width:0] tok_data_q;
   logic [31:0]               tok_count_q;
   real                       gate_q;        // absolute time at which the cycle_time gate reopens
   int unsigned               epoch_q;       // bumps on every reset assertion
   bit                        neg_warned_q;

   // Outputs are forced to their reset values combinationally so a reset
   // takes effect in the same instant, whatever the sequencer is sleeping on.
   assign L_enable  = _RESET & en_q;
   assign tok_data  = (_RESET === 1'b1) ? tok_data_q  : '1;
   assign tok_count = (_RESET === 1'b1) ? tok_count_q : '0;
   assign proto_err = _RESET & (main_err_q | mon_err_q);
   assign done      = _RESET & done_q;

   // A short reset pulse may fall between two sleep slices; the epoch lets
   // the sequencer see that it happened even after _RESET is high again.
   always @(negedge _RESET) begin
      epoch_q <= epoch_q + 1;
   end

   // Sleep until an absolute time; returns early with aborted=1 on reset.
   task automatic sleep_until(input real t_end, input int unsigned ep, output bit aborted);
      real step;
      aborted = (_RESET !== 1'b1) || (epoch_q != ep);
      while (!aborted && (($realtime + EPS) < t_end)) begin
         step = t_end - $realtime;
         if (step > POLL) begin
            step = POLL;
         end
         #(step);
         aborted = (_RESET !== 1'b1) || (epoch_q != ep);
      end
   endtask

   // Handshake sequencer. Any abort breaks out of the loop; the process then
   // restarts from the top, which is the IDLE/reset behaviour.
   always begin : fsm_proc
      int unsigned ep;
      bit          ab;
      real         t_rel;

      // IDLE
      state_q     = ST_IDLE;
      en_q        = 1'b0;
      done_q      = 1'b0;
      main_err_q  = 1'b0;
      tok_data_q  = '1;
      tok_count_q = '0;
      gate_q      = 0.0;
      if (HAS_NEG && !neg_warned_q && (_RESET !== 1'b1)) begin
         $warning("%m: negative delay parameter(s) modelled as zero");
         neg_warned_q = 1'b1;
      end
      wait (_RESET === 1'b1);
      ep = epoch_q;

      forever begin
         // ENABLE: the enable is always low on entry, so valid data here
         // was driven without a request.
         state_q = ST_ENABLE;
         if (L_data >= 0) begin
            main_err_q = 1'b1;
            $warning("%m: protocol violation: data valid without a request");
         end

         // Stall and cycle_time gate overlap; rise at the later of the two.
         t_rel = gate_q;
         if ((stall_period > 0) && (tok_count_q != 32'd0) &&
             ((tok_count_q % 32'(stall_period)) == 32'd0)) begin
            if (($realtime + STALL_D) > t_rel) begin
               t_rel = $realtime + STALL_D;
            end
         end
         sleep_until(t_rel, ep, ab);
         if (ab) break;

         en_q = 1'b1;
         wait ((L_data >= 0) || (_RESET !== 1'b1) || (epoch_q != ep));
         if ((_RESET !== 1'b1) || (epoch_q != ep)) break;

         // Capture: token and count update together, gate closes.
         tok_data_q  = L_data;
         tok_count_q = tok_count_q + 32'd1;
         gate_q      = $realtime + CT_D;
         state_q     = ST_HOLD;

         // HOLD
         sleep_until($realtime + FBV_D, ep, ab);
         if (ab) break;
         state_q = ST_RELEASE;
         en_q    = 1'b0;

         // RELEASE
         wait ((L_data < 0) || (_RESET !== 1'b1) || (epoch_q != ep));
         if ((_RESET !== 1'b1) || (epoch_q != ep)) break;

         // RECOVER
         state_q = ST_RECOVER;
         sleep_until($realtime + FBN_D, ep, ab);
         if (ab) break;

         if ((max_tokens > 0) && (tok_count_q == 32'(max_tokens))) begin
            // Terminal: enable stays low until the next reset.
            done_q = 1'b1;
            wait ((_RESET !== 1'b1) || (epoch_q != ep));
            break;
         end
      end
   end

   // Protocol monitor. Reports only; never influences the handshake.
   always begin : proto_mon
      @(L_data or _RESET or state_q or done_q);
      if (_RESET !== 1'b1) begin
         mon_err_q = 1'b0;
      end else begin
         if ((state_q == ST_HOLD) && (L_data >= 0) && (L_data != tok_data_q)) begin
            mon_err_q = 1'b1;
            $warning("%m: protocol violation: data changed while held");
         end
         if ((state_q == ST_HOLD) && (L_data < 0)) begin
            mon_err_q = 1'b1;
            $warning("%m: protocol violation: neutral before enable fell");
         end
         if ((done_q == 1'b1) && (L_data >= 0)) begin
            mon_err_q = 1'b1;
            $warning("%m: protocol violation: data after token limit");
         end
      end
   end

endmodule

// File: tb/tb_channel_timing_sink.sv
// Directed bench for channel_timing_sink: three instances (defaults, stalls,
// token limit), each driven by a scripted producer. Expected times in ps.

`ifndef PRS2VERILOG_TAU
`define PRS2VERILOG_TAU 1.0
`endif

module tb_channel_timing_sink;
   timeunit 1ns;
   timeprecision 1fs;

   localparam int  BW  = 4;
   localparam real TAU = `PRS2VERILOG_TAU;

   logic [2:0]         rst_n;
   logic signed [BW:0] dat [3];
   wire [2:0]          en_w;
   wire [2:0]          perr_w;
   wire [2:0]          done_w;
   wire signed [BW:0]  td_w [3];
   wire [31:0]         cnt_w [3];

   int n_tests;
   int n_fail;
   bit timed_out;
   int c_rises;

   channel_timing_sink #(.bit_width(BW)) u_dflt (
      ._RESET(rst_n[0]), .L_data(dat[0]), .L_enable(en_w[0]), .tok_data(td_w[0]),
      .tok_count(cnt_w[0]), .proto_err(perr_w[0]), .done(done_w[0]));

   channel_timing_sink #(.bit_width(BW), .stall_period(3), .stall_len(50.0)) u_stall (
      ._RESET(rst_n[1]), .L_data(dat[1]), .L_enable(en_w[1]), .tok_data(td_w[1]),
      .tok_count(cnt_w[1]), .proto_err(perr_w[1]), .done(done_w[1]));

   channel_timing_sink #(.bit_width(BW), .max_tokens(4)) u_lim (
      ._RESET(rst_n[2]), .L_data(dat[2]), .L_enable(en_w[2]), .tok_data(td_w[2]),
      .tok_count(cnt_w[2]), .proto_err(perr_w[2]), .done(done_w[2]));

   always @(posedge en_w[2]) begin
      c_rises <= c_rises + 1;
   end

   initial begin
      #(50000.0);
      timed_out = 1'b1;
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint ps(input real t);
      return longint'(t * 1000.0);
   endfunction

   // One producer handshake: data resp after the enable rise, neutral rel
   // after the enable fall. Returns the four edge times.
   task automatic hs(input int k, input int val, input real resp, input real rel,
                     output real tr, output real tv, output real tf, output real tn);
      wait ((en_w[k] === 1'b1) || timed_out);
      tr = $realtime;
      #(resp);
      dat[k] = (BW+1)'(val);
      tv = $realtime;
      wait ((en_w[k] === 1'b0) || timed_out);
      tf = $realtime;
      #(rel);
      dat[k] = -1;
      tn = $realtime;
   endtask

   initial begin
      real tr, tv, tf, tn, prev_tr, prev_tn, min_gap;
      int  rc;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = '0;
      for (int k = 0; k < 3; k++) dat[k] = -1;
      prev_tr = 0.0;
      prev_tn = 0.0;

      // Reset values
      #(5.0);
      check("rst_en",   en_w[0],   0);
      check("rst_data", td_w[0],  -1);
      check("rst_cnt",  cnt_w[0],  0);
      check("rst_perr", perr_w[0], 0);
      check("rst_done", done_w[0], 0);
      #(5.0);
      rst_n = '1;

      // Ten tokens, producer 1 tau after each rise
      min_gap = 1.0e9;
      for (int i = 0; i < 10; i++) begin
         hs(0, i, 1.0 * TAU, 0.0, tr, tv, tf, tn);
         if ((i > 0) && ((tr - prev_tr) < min_gap)) min_gap = tr - prev_tr;
         prev_tr = tr;
      end
      check("gap_ge18", ps(min_gap) >= ps(18.0 * TAU), 1);
      check("ten_cnt",  cnt_w[0], 10);
      check("ten_data", td_w[0],   9);
      check("ten_perr", perr_w[0], 0);

      // Feedback delays, zero-delay producer
      hs(0, 1, 0.0, 0.0, tr, tv, tf, tn);
      check("fall_6p75", ps(tf - tv), ps(6.75 * TAU));
      prev_tn = tn;
      hs(0, 2, 0.0, 5.0 * TAU, tr, tv, tf, tn);
      check("rise_gate", ps(tr - prev_tn), ps(11.25 * TAU));
      prev_tn = tn;
      hs(0, 3, 0.0, 0.0, tr, tv, tf, tn);
      check("rise_7p25", ps(tr - prev_tn), ps(7.25 * TAU));
      check("fb_cnt",  cnt_w[0], 13);
      check("fb_data", td_w[0],   3);

      // Data changes 5->6 while held
      wait ((en_w[0] === 1'b1) || timed_out);
      dat[0] = 5;
      #(1.0 * TAU);
      dat[0] = 6;
      wait ((en_w[0] === 1'b0) || timed_out);
      dat[0] = -1;
      #(1.0 * TAU);
      check("chg_perr", perr_w[0], 1);
      check("chg_data", td_w[0],   5);
      check("chg_cnt",  cnt_w[0], 14);
      hs(0, 7, 0.0, 0.0, tr, tv, tf, tn);
      check("chg_next_cnt",  cnt_w[0], 15);
      check("chg_next_data", td_w[0],   7);
      check("chg_sticky",    perr_w[0], 1);

      // Reset mid-handshake
      rst_n[0] = 1'b0;
      #(2.0 * TAU);
      check("pulse_perr", perr_w[0], 0);
      rst_n[0] = 1'b1;
      hs(0, 10, 1.0 * TAU, 0.0, tr, tv, tf, tn);
      hs(0, 11, 1.0 * TAU, 0.0, tr, tv, tf, tn);
      wait ((en_w[0] === 1'b1) || timed_out);
      #(1.0 * TAU);
      dat[0] = 12;
      #(2.0 * TAU);
      rst_n[0] = 1'b0;
      #(0.01 * TAU);
      check("mid_rst_en",   en_w[0],   0);
      check("mid_rst_data", td_w[0],  -1);
      check("mid_rst_cnt",  cnt_w[0],  0);
      dat[0] = -1;
      #(5.0 * TAU);
      rst_n[0] = 1'b1;
      hs(0, 13, 1.0 * TAU, 0.0, tr, tv, tf, tn);
      check("post_rst_cnt",  cnt_w[0],  1);
      check("post_rst_data", td_w[0],  13);

      // Stalls every 3 tokens, 50 tau
      for (int i = 1; i <= 8; i++) begin
         hs(1, i, 0.0, 0.0, tr, tv, tf, tn);
         if (i >= 2) begin
            check($sformatf("stall_gap%0d", i), ps(tr - prev_tn),
                  ((i == 4) || (i == 7)) ? ps(57.25 * TAU) : ps(11.25 * TAU));
         end
         prev_tn = tn;
      end

      // Token limit of 4
      for (int i = 1; i <= 4; i++) begin
         hs(2, i, 0.0, 0.0, tr, tv, tf, tn);
         if (i == 3) check("lim_done_early", done_w[2], 0);
      end
      #(10.0 * TAU);
      check("lim_done", done_w[2], 1);
      check("lim_en",   en_w[2],   0);
      check("lim_cnt",  cnt_w[2],  4);
      check("lim_perr", perr_w[2], 0);
      rc = c_rises;
      #(1000.0 * TAU);
      check("lim_no_rise", c_rises - rc, 0);
      check("lim_en_hold", en_w[2], 0);
      dat[2] = 3;
      #(1.0 * TAU);
      check("lim_late_perr", perr_w[2], 1);
      check("lim_late_cnt",  cnt_w[2],  4);

      check("timeout", timed_out, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
